// File: rtl/keypad_conditioner_if.sv
// Keypad conditioner signal bundle: raw switch inputs toward the
// conditioner, cleaned strobe/digit and debug status back out.
interface keypad_conditioner_if;
    logic [3:0] raw_digit;
    logic       raw_enter;
    logic [3:0] digit_out;
    logic       enter_pulse;
    logic       busy;
    logic [3:0] glitch_cnt;
    logic [2:0] fsm_state;

    // Driver of the raw switches / consumer of the cleaned outputs.
    modport master (
        output raw_digit, raw_enter,
        input  digit_out, enter_pulse, busy, glitch_cnt, fsm_state
    );

    // The conditioner itself.
    modport slave (
        input  raw_digit, raw_enter,
        output digit_out, enter_pulse, busy, glitch_cnt, fsm_state
    );
endinterface

// File: rtl/keypad_conditioner.sv
// Keypad conditioner: synchronizes the asynchronous digit switches and the
// bouncing enter button, debounces press and release, and emits one
// enter_pulse per accepted press together with the digit captured at that
// press. Aborted presses are counted in a saturating 4-bit glitch counter.
module keypad_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    keypad_conditioner_if.slave  kp
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] PRESS_WAIT   = 3'd1;
    localparam logic [2:0] FIRE         = 3'd2;
    localparam logic [2:0] HELD         = 3'd3;
    localparam logic [2:0] RELEASE_WAIT = 3'd4;

    // Terminal count of the debounce window; the counter never passes it.
    localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_enter, s_enter;
    logic [3:0] sync1_digit, s_digit;
    logic [2:0] state;
    logic [7:0] cnt;
    logic [3:0] cand_digit;
    logic [3:0] digit_q;
    logic [3:0] glitch_q;

    // Two-flop synchronizers; only the second stage feeds the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_enter <= 1'b0;
            s_enter     <= 1'b0;
            sync1_digit <= 4'd0;
            s_digit     <= 4'd0;
        end else begin
            sync1_enter <= kp.raw_enter;
            s_enter     <= sync1_enter;
            sync1_digit <= kp.raw_digit;
            s_digit     <= sync1_digit;
        end
    end

    // Debounce FSM with its window counter, candidate digit, captured digit
    // and glitch counter. Every state change clears the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            cand_digit <= 4'd0;
            digit_q    <= 4'd0;
            glitch_q   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_enter) begin
                        state      <= PRESS_WAIT;
                        cnt        <= 8'd0;
                        cand_digit <= s_digit;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_enter) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        if (glitch_q != 4'd15)
                            glitch_q <= glitch_q + 4'd1;
                    end else if (s_digit != cand_digit) begin
                        // Digit still settling: restart the window on the new value.
                        cand_digit <= s_digit;
                        cnt        <= 8'd0;
                    end else if (cnt == LAST_CNT) begin
                        state   <= FIRE;
                        cnt     <= 8'd0;
                        digit_q <= cand_digit;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FIRE: begin
                    state <= HELD;
                    cnt   <= 8'd0;
                end
                HELD: begin
                    if (!s_enter) begin
                        state <= RELEASE_WAIT;
                        cnt   <= 8'd0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s_enter) begin
                        // Release bounce: back to HELD silently.
                        state <= HELD;
                        cnt   <= 8'd0;
                    end else if (cnt == LAST_CNT) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Outputs decoded straight from registers, no extra latency.
    assign kp.digit_out   = digit_q;
    assign kp.enter_pulse = (state == FIRE);
    assign kp.busy        = (state != IDLE);
    assign kp.glitch_cnt  = glitch_q;
    assign kp.fsm_state   = state;

endmodule
